// File: rtl/uart_word_link.sv
// uart_word_link: packs UART RX bytes into words and splits words into UART TX bytes, LSB first.
// Define UART_WORD_LINK_TIMEOUT_EN to drop a partial RX word after TIMEOUT_CYCLES of silence.

module uart_word_link #(
    parameter int DATA_BITS      = 8,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx_empty,
    input  logic [DATA_BITS-1:0]            r_data,
    output logic                            rd_uart,
    input  logic                            tx_full,
    output logic                            wr_uart,
    output logic [DATA_BITS-1:0]            w_data,
    output logic [DATA_BITS*WORD_BYTES-1:0] rx_word,
    output logic                            rx_word_valid,
    input  logic                            rx_word_ready,
    input  logic [DATA_BITS*WORD_BYTES-1:0] tx_word,
    input  logic                            tx_word_valid,
    output logic                            tx_word_ready,
    output logic                            rx_timeout
);

    localparam int            W    = DATA_BITS * WORD_BYTES;
    localparam int            CW   = $clog2(WORD_BYTES);
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    typedef enum logic {COLLECT, HOLD} rx_state_t;
    typedef enum logic {IDLE, SEND} tx_state_t;

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic            rx_pop;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [W-1:0]    tx_shift;

    // Reset gates the decoded handshakes so nothing moves while it is held
    assign rx_pop        = reset && (rx_state == COLLECT) && !rx_empty;
    assign rd_uart       = rx_pop;
    assign tx_word_ready = reset && (tx_state == IDLE);
    assign wr_uart       = (tx_state == SEND) && !tx_full;
    assign w_data        = tx_shift[DATA_BITS-1:0];

`ifdef UART_WORD_LINK_TIMEOUT_EN
    localparam int            IW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] idle_cnt;
`else
    // Constant 0: TIMEOUT_CYCLES only matters when the idle counter exists
    assign rx_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state      <= COLLECT;
            rx_cnt        <= '0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
`ifdef UART_WORD_LINK_TIMEOUT_EN
            idle_cnt      <= '0;
            rx_timeout    <= 1'b0;
`endif
        end else begin
`ifdef UART_WORD_LINK_TIMEOUT_EN
            rx_timeout <= 1'b0;
`endif
            unique case (rx_state)
                COLLECT: begin
                    if (rx_pop) begin
                        rx_word[int'(rx_cnt)*DATA_BITS +: DATA_BITS] <= r_data;
`ifdef UART_WORD_LINK_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (rx_cnt == LAST) begin
                            rx_cnt        <= '0;
                            rx_word_valid <= 1'b1;
                            rx_state      <= HOLD;
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
`ifdef UART_WORD_LINK_TIMEOUT_EN
                    // A pop in the expiry cycle wins, so only silence can time out
                    else if (rx_cnt != '0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            rx_cnt     <= '0;
                            idle_cnt   <= '0;
                            rx_timeout <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
`endif
                end
                HOLD: begin
                    if (rx_word_ready) begin
                        rx_word_valid <= 1'b0;
                        rx_state      <= COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
        end else begin
            unique case (tx_state)
                IDLE: begin
                    if (tx_word_valid) begin
                        tx_shift <= tx_word;
                        tx_cnt   <= '0;
                        tx_state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        tx_shift <= tx_shift >> DATA_BITS;
                        if (tx_cnt == LAST) begin
                            tx_cnt   <= '0;
                            tx_state <= IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_link.sv
// tb_uart_word_link: scoreboard bench with a queue-based UART FIFO model.
// Expected words/bytes are built from the byte stream at stimulus time.

module tb_uart_word_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic        rx_word_ready;
    logic [31:0] tx_word;
    logic        tx_word_valid;
    logic        tx_word_ready;
    logic        rx_timeout;

    uart_word_link dut (
        .clk           (clk),
        .reset         (reset),
        .rx_empty      (rx_empty),
        .r_data        (r_data),
        .rd_uart       (rd_uart),
        .tx_full       (tx_full),
        .wr_uart       (wr_uart),
        .w_data        (w_data),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .rx_word_ready (rx_word_ready),
        .tx_word       (tx_word),
        .tx_word_valid (tx_word_valid),
        .tx_word_ready (tx_word_ready),
        .rx_timeout    (rx_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_fifo[$];
    logic [7:0]  acc[$];
    logic [31:0] exp_rx[$];
    logic [7:0]  exp_tx[$];
    logic        pop_pend = 1'b0;
    bit          tx_done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_rx_if();
        rx_empty = (rx_fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_fifo[0];
    endtask

    // Reference: every WORD_BYTES bytes of the stream form one word, LSB first
    task automatic push_rx_byte(input logic [7:0] b);
        logic [31:0] w;
        rx_fifo.push_back(b);
        acc.push_back(b);
        if (acc.size() == 4) begin
            w = '0;
            foreach (acc[i]) w |= 32'(acc[i]) << (8 * i);
            exp_rx.push_back(w);
            acc.delete();
        end
        update_rx_if();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        tx_word       = w;
        tx_word_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_word_ready) begin
                for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
                @(posedge clk);
                #1;
                tx_word_valid = 1'b0;
                return;
            end
        end
        check("tx_accept_timeout", 64'd0, 64'd1);
        tx_word_valid = 1'b0;
    endtask

    task automatic drain();
        rx_word_ready = 1'b1;
        tx_full       = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (exp_rx.size() == 0 && exp_tx.size() == 0 &&
                rx_fifo.size() == 0 && !wr_uart && !rx_word_valid)
                break;
            tick();
        end
        check("drain_rx_left", 64'(exp_rx.size()), 64'd0);
        check("drain_tx_left", 64'(exp_tx.size()), 64'd0);
    endtask

    // UART RX FIFO model: a pop seen at the negedge happens at the next edge
    always @(negedge clk) pop_pend = rd_uart;

    always @(posedge clk) begin
        if (pop_pend) begin
            #1;
            if (rx_fifo.size() != 0) void'(rx_fifo.pop_front());
            update_rx_if();
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands something over
    always @(negedge clk) begin
        if (rd_uart) check("rd_on_empty", 64'(rx_empty), 64'd0);
        if (rx_word_valid && rx_word_ready) begin
            if (exp_rx.size() == 0) check("rx_extra_word", 64'(rx_word), 64'hx);
            else check("rx_word", 64'(rx_word), 64'(exp_rx.pop_front()));
        end
        if (wr_uart) begin
            check("wr_while_full", 64'(tx_full), 64'd0);
            if (exp_tx.size() == 0) check("tx_extra_byte", 64'(w_data), 64'hx);
            else check("tx_byte", 64'(w_data), 64'(exp_tx.pop_front()));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd_bits, val_bits;
        logic [4:0] wr_bits;
        int         cnt;

        reset         = 1'b0;
        tx_full       = 1'b0;
        tx_word       = '0;
        tx_word_valid = 1'b0;
        rx_word_ready = 1'b1;
        update_rx_if();

        // Reset state, with bytes already waiting in the FIFO
        push_rx_byte(8'h78);
        push_rx_byte(8'h56);
        push_rx_byte(8'h34);
        push_rx_byte(8'h12);
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_uart", 64'(rd_uart), 64'd0);
        check("rst_rx_word", 64'(rx_word), 64'd0);
        check("rst_rx_valid", 64'(rx_word_valid), 64'd0);
        check("rst_tx_ready", 64'(tx_word_ready), 64'd0);
        check("rst_wr_uart", 64'(wr_uart), 64'd0);
        check("rst_w_data", 64'(w_data), 64'd0);
        check("rst_timeout", 64'(rx_timeout), 64'd0);

        // Full-rate RX: four back-to-back pops, valid for exactly one cycle
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_bits[i]  = rd_uart;
            val_bits[i] = rx_word_valid;
        end
        check("rx_rd_pattern", 64'(rd_bits), 64'h0f);
        check("rx_valid_pattern", 64'(val_bits), 64'h10);
        check("idle_tx_ready", 64'(tx_word_ready), 64'd1);

        // Backpressure: one word held, no further pops
        tick();
        rx_word_ready = 1'b0;
        for (int b = 1; b <= 8; b++) push_rx_byte(8'(b));
        repeat (10) tick();
        @(negedge clk);
        check("hold_fifo_left", 64'(rx_fifo.size()), 64'd4);
        check("hold_rd_uart", 64'(rd_uart), 64'd0);
        check("hold_valid", 64'(rx_word_valid), 64'd1);
        check("hold_word", 64'(rx_word), 64'h04030201);
        tick();
        drain();

        // TX word with no backpressure
        send_word(32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_bits[i] = wr_uart;
        end
        check("tx_wr_pattern", 64'(wr_bits), 64'h0f);
        check("tx_ready_after", 64'(tx_word_ready), 64'd1);
        tick();

        // TX word stalled by tx_full after the second byte
        send_word(32'hDEADBEEF);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge clk);
            if (wr_uart) cnt++;
        end
        check("tx_two_bytes", 64'(cnt), 64'd2);
        tick();
        tx_full = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_uart) cnt++;
        end
        check("tx_stall_writes", 64'(cnt), 64'd0);
        check("tx_stall_ready", 64'(tx_word_ready), 64'd0);
        check("tx_stall_left", 64'(exp_tx.size()), 64'd2);
        tick();
        tx_full = 1'b0;
        drain();

        // Reset in the middle of an RX word discards the partial bytes
        push_rx_byte(8'h99);
        push_rx_byte(8'h98);
        for (int i = 0; i < 20 && rx_fifo.size() != 0; i++) tick();
        tick();
        reset = 1'b0;
        acc.delete();
        repeat (2) tick();
        reset = 1'b1;
        rx_word_ready = 1'b0;
        push_rx_byte(8'hAA);
        push_rx_byte(8'hBB);
        push_rx_byte(8'hCC);
        push_rx_byte(8'hDD);
        for (int i = 0; i < 20 && !rx_word_valid; i++) tick();
        @(negedge clk);
        check("post_reset_word", 64'(rx_word), 64'hDDCCBBAA);
        tick();
        drain();

        // Randomized concurrent RX and TX traffic
        fork
            begin
                int i = 0;
                while (i < 400 || !tx_done) begin
                    rx_word_ready = ($urandom_range(0, 9) < 7);
                    tx_full       = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 9) < 4) push_rx_byte(8'($urandom));
                    tick();
                    i++;
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send_word($urandom);
                end
                tx_done = 1'b1;
            end
        join
        drain();
        check("final_timeout", 64'(rx_timeout), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_link.md
Name: uart_word_link

Overview:
- Host-side client of the UART byte interface (rd_uart/r_data/rx_empty, wr_uart/w_data/tx_full).
- RX path: pops bytes from the UART RX FIFO and assembles them into words. Presents each word on a valid/ready handshake.
- TX path: accepts words on a valid/ready handshake and serializes them into the UART TX FIFO as bytes.
- Sits between the UART block and the debug/loader unit. All bytes travel least-significant byte first.

Parameters:
- DATA_BITS, 8: UART byte width; must match the UART instance.
- WORD_BYTES, 4: bytes per word, ≥2. Word width W = DATA_BITS*WORD_BYTES.
- TIMEOUT_CYCLES, 1000000: inter-byte RX timeout in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_empty  in  1  UART RX FIFO empty.
- r_data  in  DATA_BITS  UART RX FIFO head byte; valid whenever rx_empty=0.
- rd_uart  out  1  pop UART RX FIFO (one byte per high cycle).
- tx_full  in  1  UART TX FIFO full.
- wr_uart  out  1  push w_data into UART TX FIFO.
- w_data  out  DATA_BITS  byte to transmit.
- rx_word  out  W  assembled word.
- rx_word_valid  out  1  rx_word holds a complete word.
- rx_word_ready  in  1  consumer accepts rx_word.
- tx_word  in  W  word to send.
- tx_word_valid  in  1  tx_word present.
- tx_word_ready  out  1  block can accept tx_word.
- rx_timeout  out  1  one-cycle pulse: partial word discarded.

Behaviour:
- Reset (reset=0, async):
  - rx_word=0, rx_word_valid=0, rx byte count=0.
  - TX shift register=0, tx count=0.
  - Both FSMs go to their first state.
  - rd_uart=0, wr_uart=0, tx_word_ready=0 while reset is held. w_data reflects the shift register, so it is 0.
- RX FSM states COLLECT, HOLD:
  - COLLECT: rd_uart = !rx_empty (combinational). On each pop, r_data is written into byte slot rx_cnt of rx_word (slot 0 = bits [DATA_BITS-1:0]), then rx_cnt++.
  - Pop with rx_cnt=WORD_BYTES-1: rx_cnt goes to 0, rx_word_valid goes to 1 on the next edge, state goes to HOLD.
  - Throughput: one byte per cycle.
  - HOLD: rd_uart=0. rx_word stable. When rx_word_valid && rx_word_ready, valid drops next edge and the state returns to COLLECT.
  - No pop occurs in the cycle the word is accepted; popping resumes the cycle after.
- TX FSM states IDLE, SEND:
  - IDLE: tx_word_ready=1 (decoded from state register). When tx_word_valid=1, tx_word loads into the shift register, tx_cnt=0, state goes to SEND.
  - SEND: tx_word_ready=0. w_data = shift[DATA_BITS-1:0]. wr_uart = !tx_full.
  - On each write, shift right by DATA_BITS and tx_cnt++.
  - Write with tx_cnt=WORD_BYTES-1: state returns to IDLE.
  - Latency: word accepted at edge N, first byte written at cycle N+1 if tx_full=0. tx_full=1 stalls SEND with no byte lost or duplicated.
  - Back-to-back words: at most one idle cycle between the last byte of one word and the first byte of the next.
- RX and TX paths are fully independent; simultaneous activity is legal.
- A reset mid-word discards any partial RX word and any unsent TX bytes.
- Counters are $clog2(WORD_BYTES) bits wide. Wrap back to 0 is explicit, not modular overflow.

Optional Feature:
- Macro: UART_WORD_LINK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT while rx_cnt≠0. It clears on every pop.
  - When it reaches TIMEOUT_CYCLES-1 with no pop: rx_cnt goes to 0, partial bytes are discarded, rx_timeout pulses high for 1 cycle, and the counter clears.
  - A pop in the same cycle as expiry wins: the byte is stored and there is no timeout.
- Not defined: no counter is built, rx_timeout is tied to 0, and a partial word waits indefinitely.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 with rx_empty=0 continuously and rx_word_ready=1 -> 4 consecutive rd_uart pulses, rx_word=0x12345678, rx_word_valid high exactly 1 cycle.
- 8 bytes 0x01..0x08 queued, rx_word_ready held 0 for 10 cycles -> exactly 4 pops, then rd_uart=0 while valid holds 0x04030201. Raise ready -> the second word is 0x08070605.
- tx_word=0xDEADBEEF, valid for 1 cycle, tx_full=0 -> wr_uart for 4 consecutive cycles, w_data = 0xEF,0xBE,0xAD,0xDE, then tx_word_ready=1.
- Same TX word with tx_full=1 for 5 cycles after the second byte -> sequence 0xEF,0xBE,(stall),0xAD,0xDE; no repeats, no drops.
- Reset driven to 0 after 2 of 4 RX bytes, then released, then 4 new bytes 0xAA,0xBB,0xCC,0xDD -> rx_word=0xDDCCBBAA.
- With UART_WORD_LINK_TIMEOUT_EN and TIMEOUT_CYCLES=16: 2 bytes, then silence -> rx_timeout pulse 16 cycles after the last pop. The next 4 bytes 0x11,0x22,0x33,0x44 -> rx_word=0x44332211.
